// File: rtl/rtc_save_restore.sv
// Collects the five RTC save words from the save loader into shadows and commits them to
// the MBC3 RTC after the write stream goes quiet. Optional image check: RTC_RESTORE_CHECK_EN.
module rtc_save_restore #(
  parameter int QUIET_CYCLES   = 16,
  parameter int LOAD_PULSE_LEN = 1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        cart_download,
  input  logic        bk_rtc_wr,
  input  logic [16:0] bk_addr,
  input  logic [15:0] bk_data,
  output logic [31:0] RTC_timestampIn,
  output logic [47:0] RTC_savedtimeIn,
  output logic        RTC_load,
  output logic        rtc_restored,
  output logic        rtc_reject,
  output logic [1:0]  fsm_state
);

  localparam int QW = $clog2(QUIET_CYCLES + 1);
  localparam int PW = $clog2(LOAD_PULSE_LEN + 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SETTLE  = 2'd1,
    COMMIT  = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [15:0]    shadow [5];
  logic [4:0]     rx_mask;
  logic [QW-1:0]  quiet_cnt;
  logic [PW-1:0]  pulse_cnt;
  logic [7:0]     idx;
  logic           wr_ok;
  logic [4:0]     wr_bit;
  logic [31:0]    ts_shadow;
  logic [47:0]    st_shadow;
  logic           image_bad;
  logic           unused_addr_bits;

  assign idx              = bk_addr[7:0];
  assign unused_addr_bits = ^bk_addr[16:8];
  // A download in progress drops any write in the same cycle.
  assign wr_ok            = bk_rtc_wr && !cart_download && (idx < 8'd5);
  assign wr_bit           = wr_ok ? (5'b00001 << idx[2:0]) : 5'b00000;
  assign ts_shadow        = {shadow[1], shadow[0]};
  assign st_shadow        = {shadow[4], shadow[3], shadow[2]};
  assign fsm_state        = state_q;

`ifdef RTC_RESTORE_CHECK_EN
  logic reject_q;

  assign image_bad = (ts_shadow == 32'h0) || (ts_shadow == 32'hFFFF_FFFF) ||
                     (st_shadow == 48'hFFFF_FFFF_FFFF);

  always_ff @(posedge clk_sys) begin
    if (reset) reject_q <= 1'b0;
    else       reject_q <= (state_q == COMMIT) && image_bad && !cart_download;
  end

  assign rtc_reject = reject_q;
`else
  assign image_bad  = 1'b0;
  assign rtc_reject = 1'b0;
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) state_q <= COLLECT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cart_download) begin
      state_d = COLLECT;
    end else begin
      case (state_q)
        COLLECT: if (rx_mask == 5'h1F) state_d = SETTLE;
        SETTLE:  if (!wr_ok && (quiet_cnt == QW'(QUIET_CYCLES - 1))) state_d = COMMIT;
        COMMIT:  state_d = image_bad ? COLLECT : DONE;
        DONE:    if (wr_ok) state_d = COLLECT;
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) shadow[i] <= 16'h0;
      rx_mask         <= 5'b0;
      quiet_cnt       <= '0;
      pulse_cnt       <= '0;
      RTC_load        <= 1'b0;
      rtc_restored    <= 1'b0;
      RTC_timestampIn <= 32'h0;
      RTC_savedtimeIn <= 48'h0;
    end else begin
      if (wr_ok) shadow[idx[2:0]] <= bk_data;

      if (cart_download) begin
        rx_mask <= 5'b0;
      end else begin
        case (state_q)
          COMMIT:  rx_mask <= wr_bit;
          // A write after a commit starts a fresh image.
          DONE:    if (wr_ok) rx_mask <= wr_bit;
          default: rx_mask <= rx_mask | wr_bit;
        endcase
      end

      if ((state_q == SETTLE) && !wr_ok && !cart_download) quiet_cnt <= quiet_cnt + QW'(1);
      else                                                   quiet_cnt <= '0;

      if (cart_download) begin
        RTC_load     <= 1'b0;
        pulse_cnt    <= '0;
        rtc_restored <= 1'b0;
      end else if ((state_q == COMMIT) && !image_bad) begin
        RTC_timestampIn <= ts_shadow;
        RTC_savedtimeIn <= st_shadow;
        rtc_restored    <= 1'b1;
        RTC_load        <= 1'b1;
        pulse_cnt       <= PW'(LOAD_PULSE_LEN);
      end else if (pulse_cnt != '0) begin
        pulse_cnt <= pulse_cnt - PW'(1);
        RTC_load  <= (pulse_cnt > PW'(1));
      end
    end
  end

endmodule

// File: tb/tb_rtc_save_restore.sv
// Directed bench for rtc_save_restore: commit latency, outputs, partial images, ignored
// indices, download abort, reset abort and the all-FFFF image (RTC_RESTORE_CHECK_EN aware).
module tb_rtc_save_restore;

  localparam int QUIET   = 16;
  localparam int LATENCY = QUIET + 1;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        cart_download;
  logic        bk_rtc_wr;
  logic [16:0] bk_addr;
  logic [15:0] bk_data;
  logic [31:0] RTC_timestampIn;
  logic [47:0] RTC_savedtimeIn;
  logic        RTC_load;
  logic        rtc_restored;
  logic        rtc_reject;
  logic [1:0]  fsm_state;

  int tests_run    = 0;
  int tests_failed = 0;
  int load_cycles  = 0;
  int reject_cycles = 0;
  int exp_loads    = 0;
  logic load_prev  = 1'b0;
  logic [79:0] exp_q[$];

  rtc_save_restore #(.QUIET_CYCLES(QUIET), .LOAD_PULSE_LEN(1)) dut (
    .clk_sys         (clk_sys),
    .reset           (reset),
    .cart_download   (cart_download),
    .bk_rtc_wr       (bk_rtc_wr),
    .bk_addr         (bk_addr),
    .bk_data         (bk_data),
    .RTC_timestampIn (RTC_timestampIn),
    .RTC_savedtimeIn (RTC_savedtimeIn),
    .RTC_load        (RTC_load),
    .rtc_restored    (rtc_restored),
    .rtc_reject      (rtc_reject),
    .fsm_state       (fsm_state)
  );

  // clock / watchdog
  always #5 clk_sys = ~clk_sys;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: each load rising edge must match the next expected {ts, st}
  always @(posedge clk_sys) begin
    if (RTC_load === 1'b1) load_cycles++;
    if (rtc_reject === 1'b1) reject_cycles++;
    if ((RTC_load === 1'b1) && !load_prev) begin
      check("sb_load_expected", 80'(exp_q.size() != 0), 80'd1);
      if (exp_q.size() != 0) begin
        logic [79:0] e;
        e = exp_q.pop_front();
        check("sb_load_ts", 80'(RTC_timestampIn), 80'(e[79:48]));
        check("sb_load_st", 80'(RTC_savedtimeIn), 80'(e[47:0]));
      end
    end
    load_prev = (RTC_load === 1'b1);
  end

  // driver tasks (called at a negedge, return at a negedge)
  task automatic idle(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic write_word(input int addr, input logic [15:0] d, input int hold);
    bk_addr   = 17'(addr);
    bk_data   = d;
    bk_rtc_wr = 1'b1;
    repeat (hold) @(negedge clk_sys);
    bk_rtc_wr = 1'b0;
  endtask

  task automatic write_image(input logic [79:0] img, input int hold);
    for (int i = 0; i < 5; i++) write_word(i, img[i*16 +: 16], hold);
  endtask

  task automatic expect_commit(input logic [79:0] img);
    exp_q.push_back({img[31:0], img[79:32]});
    exp_loads++;
  endtask

  task automatic wait_load(input int max, output int cyc);
    cyc = 0;
    while (cyc < max) begin
      @(negedge clk_sys);
      cyc++;
      if (RTC_load === 1'b1) break;
    end
  endtask

  task automatic pulse_download();
    cart_download = 1'b1;
    @(negedge clk_sys);
    cart_download = 1'b0;
  endtask

  initial begin
    int cyc;
    logic [79:0] img;

    reset = 1'b1; cart_download = 1'b0; bk_rtc_wr = 1'b0; bk_addr = '0; bk_data = '0;
    idle(3);
    check("reset_ts", 80'(RTC_timestampIn), 80'h0);
    check("reset_st", 80'(RTC_savedtimeIn), 80'h0);
    check("reset_load", 80'(RTC_load), 80'h0);
    check("reset_restored", 80'(rtc_restored), 80'h0);
    check("reset_reject", 80'(rtc_reject), 80'h0);
    check("reset_state", 80'(fsm_state), 80'h0);
    reset = 1'b0;
    idle(2);

    // 1: basic image, each word held 3 cycles
    img = 80'h5555_4444_3333_2222_1111;
    expect_commit(img);
    write_image(img, 3);
    wait_load(40, cyc);
    check("t1_latency", 80'(cyc), 80'(LATENCY));
    check("t1_ts", 80'(RTC_timestampIn), 80'h2222_1111);
    check("t1_st", 80'(RTC_savedtimeIn), 80'h5555_4444_3333);
    check("t1_restored", 80'(rtc_restored), 80'h1);
    idle(1);
    check("t1_pulse_end", 80'(RTC_load), 80'h0);
    check("t1_state_done", 80'(fsm_state), 80'h3);
    idle(3);
    check("t1_load_cycles", 80'(load_cycles), 80'(exp_loads));

    // 2: download clears restored; partial image never commits
    pulse_download();
    check("t2_restored_clr", 80'(rtc_restored), 80'h0);
    check("t2_ts_hold", 80'(RTC_timestampIn), 80'h2222_1111);
    for (int i = 0; i < 4; i++) write_word(i, 16'(16'h0101 * (i + 1)), 2);
    idle(1000);
    check("t2_no_load", 80'(load_cycles), 80'(exp_loads));
    check("t2_restored", 80'(rtc_restored), 80'h0);
    check("t2_state_collect", 80'(fsm_state), 80'h0);

    // 3: complete with w4, then rewrite w2 at quiet_cnt=10
    write_word(4, 16'h0505, 2);
    idle(10);
    check("t3_no_early_load", 80'(load_cycles), 80'(exp_loads));
    expect_commit(80'h0505_0404_AAAA_0202_0101);
    write_word(2, 16'hAAAA, 1);
    wait_load(40, cyc);
    check("t3_latency", 80'(cyc), 80'(LATENCY));
    check("t3_st_low", 80'(RTC_savedtimeIn[15:0]), 80'hAAAA);
    check("t3_st", 80'(RTC_savedtimeIn), 80'h0505_0404_AAAA);
    idle(3);
    check("t3_one_load", 80'(load_cycles), 80'(exp_loads));

    // 4: writes to indices 5..255 interleaved are ignored
    img = 80'h9999_8888_7777_6666_5A5A;
    expect_commit(img);
    write_word(5, 16'hDEAD, 2);
    write_word(0, img[15:0], 3);
    write_word(6, 16'hBEEF, 2);
    write_word(1, img[31:16], 3);
    write_word(128, 16'h1234, 2);
    write_word(2, img[47:32], 3);
    write_word(255, 16'h0000, 2);
    write_word(3, img[63:48], 3);
    write_word(17'h1_00FF, 16'hFFFF, 2);
    write_word(4, img[79:64], 3);
    wait_load(40, cyc);
    check("t4_latency", 80'(cyc), 80'(LATENCY));
    check("t4_ts", 80'(RTC_timestampIn), 80'h6666_5A5A);
    check("t4_st", 80'(RTC_savedtimeIn), 80'h9999_8888_7777);

    // 5a: download during SETTLE aborts the commit
    write_image(80'h1313_1212_1111_1010_0F0F, 3);
    idle(5);
    pulse_download();
    idle(40);
    check("t5a_no_load", 80'(load_cycles), 80'(exp_loads));
    check("t5a_restored", 80'(rtc_restored), 80'h0);
    check("t5a_ts_hold", 80'(RTC_timestampIn), 80'h6666_5A5A);
    check("t5a_st_hold", 80'(RTC_savedtimeIn), 80'h9999_8888_7777);

    // 5b: download in the same cycle as the final word drops it
    for (int i = 0; i < 4; i++) write_word(i, 16'(16'h2020 + i), 2);
    cart_download = 1'b1;
    write_word(4, 16'h2424, 1);
    cart_download = 1'b0;
    idle(40);
    check("t5b_no_load", 80'(load_cycles), 80'(exp_loads));
    check("t5b_state", 80'(fsm_state), 80'h0);
    img = 80'h3434_3333_3232_3131_3030;
    expect_commit(img);
    write_image(img, 3);
    wait_load(40, cyc);
    check("t5b_latency", 80'(cyc), 80'(LATENCY));
    check("t5b_restored", 80'(rtc_restored), 80'h1);

    // 6: all-FFFF image
    img = {5{16'hFFFF}};
`ifdef RTC_RESTORE_CHECK_EN
    write_image(img, 3);
    idle(40);
    check("t6_reject_once", 80'(reject_cycles), 80'd1);
    check("t6_no_load", 80'(load_cycles), 80'(exp_loads));
    check("t6_ts_hold", 80'(RTC_timestampIn), 80'h3131_3030);
    check("t6_st_hold", 80'(RTC_savedtimeIn), 80'h3434_3333_3232);
    check("t6_restored_hold", 80'(rtc_restored), 80'h1);
    check("t6_state", 80'(fsm_state), 80'h0);
`else
    expect_commit(img);
    write_image(img, 3);
    wait_load(40, cyc);
    check("t6_latency", 80'(cyc), 80'(LATENCY));
    check("t6_ts", 80'(RTC_timestampIn), 80'hFFFF_FFFF);
    check("t6_st", 80'(RTC_savedtimeIn), 80'hFFFF_FFFF_FFFF);
    check("t6_reject_tied", 80'(reject_cycles), 80'd0);
`endif

    // reset mid-SETTLE: nothing committed, everything cleared
    write_image(80'h4545_4444_4343_4242_4141, 3);
    idle(5);
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    idle(40);
    check("rst_no_load", 80'(load_cycles), 80'(exp_loads));
    check("rst_ts", 80'(RTC_timestampIn), 80'h0);
    check("rst_st", 80'(RTC_savedtimeIn), 80'h0);
    check("rst_restored", 80'(rtc_restored), 80'h0);

    idle(3);
    check("sb_empty", 80'(exp_q.size()), 80'd0);
    check("total_load_cycles", 80'(load_cycles), 80'(exp_loads));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
